vram_arbiter: RTL and testbench
===============================

# vram_arbiter

Single-port video RAM arbiter for the Lynx 48K core. It shares one synchronous single-port 8-bit RAM between the video fetch engine and the Z80 bus, replacing a dual-port bank. Video reads have priority. CPU accesses are stalled through `wait_n` until they are serviced. One instance sits in front of each video bank (red/blue and green/alt-green), between the CPU address/data decode and the bank RAM.

## Interface
- `AW`, 14, address width of the RAM bank.
- `STARVE`, 4, maximum consecutive video grants while a CPU request waits. Used only when the guard is compiled in.

- `clock`  in  1  system clock; all logic on the rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `vreq`  in  1  video read request, one-clock pulse.
- `va`  in  AW  video address, valid with `vreq`.
- `vdo`  out  8  video read data.
- `vack`  out  1  one-clock pulse; `vdo` is valid while it is high.
- `creq`  in  1  CPU request, held high until `cack`.
- `cwr`  in  1  1 = write, 0 = read; held with `creq`.
- `ca`  in  AW  CPU address, held with `creq`.
- `cdi`  in  8  CPU write data.
- `cdo`  out  8  CPU read data, valid with `cack`.
- `cack`  out  1  one-clock completion pulse.
- `wait_n`  out  1  `!(creq & !cack)`, combinational; drives Z80 WAIT.
- `verr`  out  1  sticky video overrun flag.
- `mem_a`  out  AW  RAM address.
- `mem_we`  out  1  RAM write enable.
- `mem_di`  out  8  RAM write data.
- `mem_do`  in  8  RAM read data; RAM has one-clock registered read latency.

## Operation
- Port-owner FSM states:
  - IDLE: port unused; `mem_a` = 0, `mem_we` = 0.
  - VID: port driven by the latched video address.
  - CPU: port driven by `ca`; `mem_we` = `cwr`; `mem_di` = `cdi`.
- Grant decision at every edge, independent of current state. This gives back-to-back grants and one access per clock.
- Video eligibility: `vreq` sampled high, or `vpend` set.
- CPU eligibility: `creq` high, `cbusy` = 0 and `cack` = 0.
- Priority: video over CPU, except when the starvation guard fires.
- Video grant: `vpend` cleared and `va` (or the held pending address) is used for the port. A `vreq` that loses the grant sets `vpend` and latches `va`.
- Overrun: `vreq` sampled high while `vpend` = 1 and video is not granted at that edge. Sets `verr`; the new address replaces the pending one. `verr` clears only on reset.
- CPU grant sets `cbusy`. `cbusy` is cleared at the edge that ends the `cack` pulse, so each request produces exactly one access. The requester drops `creq` during the `cack` cycle.
- Video reads: a tag pipeline captures `mem_do` into `vdo` one edge after the RAM edge and pulses `vack`.
- CPU reads: same capture path into `cdo`, then `cack` pulses.
- CPU writes: the RAM writes at the edge that ends the CPU state; `cack` pulses in the following cycle. `cdo` is unchanged.
- `vdo` and `cdo` hold their last captured value.

## Timing
- Video read, no contention: `vreq` sampled at edge t -> VID during cycle t..t+1 -> `vack` high t+2..t+3 with valid `vdo`. Latency is 2 clocks.
- CPU read, port free: `creq` sampled at edge t -> CPU state t..t+1 -> `cack` high t+2..t+3.
- CPU write, port free: `creq` sampled at edge t -> RAM write at t+1 -> `cack` high t+1..t+2.
- A CPU request losing to video waits one clock per video grant.
- Simultaneous `vreq` and an eligible CPU request: video wins; CPU is granted at the next edge unless video is eligible again.
- Reset (asynchronous, any state):
  - state = IDLE; `vpend`, `cbusy` = 0; guard counter = 0.
  - `vdo`, `cdo` = 0; `vack`, `cack`, `verr` = 0.
  - `mem_we` = 0 immediately, so a write in flight is aborted.
  - `wait_n` follows `creq`.

## Configuration
- `VRAM_ARB_STARVE_GUARD_EN` defined:
  - A counter (width `$clog2(STARVE+1)`) increments on each video grant made while the CPU is eligible.
  - When it equals `STARVE` and both requesters are eligible, the CPU is granted, the counter clears and video goes to `vpend`.
  - The counter clears on every CPU grant, and on any edge where the CPU is not eligible.
- Not defined: strict video priority, no counter logic. Continuous `vreq` starves the CPU indefinitely.

## Test plan
- Reset, then one `vreq` with `va`=0x0123 and RAM[0x0123]=0xA5 -> `vack` one clock, 2 edges later, with `vdo`=0xA5; `verr`=0.
- CPU write 0x3C to 0x1FFF, then CPU read of 0x1FFF -> write `cack` after 1 edge; read `cack` after 2 edges with `cdo`=0x3C; `wait_n` low exactly until each `cack`.
- `vreq` and CPU read asserted at the same edge -> video granted first; CPU granted the next edge; `cack` at t+3; `vack` at t+2.
- `vreq` every clock for 20 clocks with CPU read pending:
  - guard enabled, `STARVE`=4 -> CPU granted after 4 video grants; the displaced video access completes one clock late.
  - guard disabled -> `cack` never asserts during the burst.
- Two `vreq` pulses while one is still pending (guard forcing a CPU grant) -> `verr`=1 and stays 1 until reset; the later address is serviced.
- Assert `reset` low during a CPU write state -> `mem_we` falls immediately, RAM is unchanged, and all outputs take their reset values.

Source files
------------

// File: rtl/vram_arbiter.sv
// vram_arbiter: shares one synchronous single-port 8-bit video RAM bank between
// the video fetch engine (priority) and the Z80 bus (stalled through wait_n).
// The port owner is re-decided at every clock edge, giving one access per clock.
// Optional CPU starvation guard: define VRAM_ARB_STARVE_GUARD_EN.
module vram_arbiter #(
    parameter int unsigned AW     = 14,
    parameter int unsigned STARVE = 4
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          vreq,
    input  logic [AW-1:0] va,
    output logic [7:0]    vdo,
    output logic          vack,
    input  logic          creq,
    input  logic          cwr,
    input  logic [AW-1:0] ca,
    input  logic [7:0]    cdi,
    output logic [7:0]    cdo,
    output logic          cack,
    output logic          wait_n,
    output logic          verr,
    output logic [AW-1:0] mem_a,
    output logic          mem_we,
    output logic [7:0]    mem_di,
    input  logic [7:0]    mem_do
);

    typedef enum logic [1:0] {S_IDLE, S_VID, S_CPU} state_t;
    typedef enum logic [1:0] {T_NONE, T_VID, T_CRD} tag_t;

    state_t        r_state;
    state_t        w_state_nxt;
    tag_t          r_tag;
    logic          r_vpend;
    logic          r_cbusy;
    logic          r_vack;
    logic          r_cack;
    logic          r_verr;
    logic [AW-1:0] r_vaddr;
    logic [AW-1:0] r_paddr;
    logic [7:0]    r_vdo;
    logic [7:0]    r_cdo;

    logic          w_veligible;
    logic          w_celigible;
    logic          w_force;
    logic          w_vgrant;
    logic          w_cgrant;

    assign w_veligible = vreq | r_vpend;
    assign w_celigible = creq & ~r_cbusy & ~r_cack;
    assign w_vgrant    = w_veligible & ~w_force;
    assign w_cgrant    = w_celigible & ~w_vgrant;

`ifdef VRAM_ARB_STARVE_GUARD_EN
    localparam int unsigned CW = $clog2(STARVE + 1);

    logic [CW-1:0] r_cnt;

    assign w_force = (r_cnt == CW'(STARVE)) & w_veligible & w_celigible;

    // Count video grants that overtake a waiting CPU; restart whenever the CPU is served or idle
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_cnt <= '0;
        end else if (w_cgrant || !w_celigible) begin
            r_cnt <= '0;
        end else if (w_vgrant) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end
`else
    logic w_unused_starve;

    assign w_force         = 1'b0;
    assign w_unused_starve = ^STARVE;
`endif

    // Port-owner state register
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next owner from this edge's grant, and RAM port drive from the current owner
    always_comb begin
        w_state_nxt = S_IDLE;
        mem_a       = '0;
        mem_we      = 1'b0;
        mem_di      = '0;
        if (w_vgrant) begin
            w_state_nxt = S_VID;
        end else if (w_cgrant) begin
            w_state_nxt = S_CPU;
        end
        case (r_state)
            S_VID: begin
                mem_a = r_paddr;
            end
            S_CPU: begin
                mem_a  = ca;
                mem_we = cwr;
                mem_di = cdi;
            end
            default: begin
            end
        endcase
    end

    // Video request bookkeeping: port address on grant, pending slot and overrun flag otherwise.
    // A pending access is served before a same-edge new request, which then becomes pending.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_vpend <= 1'b0;
            r_vaddr <= '0;
            r_paddr <= '0;
            r_verr  <= 1'b0;
        end else if (w_vgrant) begin
            r_paddr <= r_vpend ? r_vaddr : va;
            r_vpend <= r_vpend & vreq;
            if (r_vpend && vreq) begin
                r_vaddr <= va;
            end
        end else if (vreq) begin
            r_vpend <= 1'b1;
            r_vaddr <= va;
            if (r_vpend) begin
                r_verr <= 1'b1;
            end
        end
    end

    // Read-tag pipeline, data capture, completion pulses and CPU one-access-per-request lock
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_tag   <= T_NONE;
            r_vdo   <= '0;
            r_cdo   <= '0;
            r_vack  <= 1'b0;
            r_cack  <= 1'b0;
            r_cbusy <= 1'b0;
        end else begin
            r_vack <= 1'b0;
            r_cack <= 1'b0;
            if (r_tag == T_VID) begin
                r_vdo  <= mem_do;
                r_vack <= 1'b1;
            end
            if (r_tag == T_CRD) begin
                r_cdo  <= mem_do;
                r_cack <= 1'b1;
            end
            if (r_state == S_CPU && cwr) begin
                r_cack <= 1'b1;
            end
            if (r_state == S_VID) begin
                r_tag <= T_VID;
            end else if (r_state == S_CPU && !cwr) begin
                r_tag <= T_CRD;
            end else begin
                r_tag <= T_NONE;
            end
            if (w_cgrant) begin
                r_cbusy <= 1'b1;
            end else if (r_cack) begin
                r_cbusy <= 1'b0;
            end
        end
    end

    assign vdo    = r_vdo;
    assign vack   = r_vack;
    assign cdo    = r_cdo;
    assign cack   = r_cack;
    assign verr   = r_verr;
    assign wait_n = ~(creq & ~r_cack);

endmodule

// File: tb/tb_vram_arbiter.sv
`timescale 1ns/1ps
// tb_vram_arbiter: scoreboard bench for vram_arbiter with a behavioural bank RAM.
module tb_vram_arbiter;

    localparam int unsigned AW     = 14;
    localparam int unsigned STARVE = 4;
`ifdef VRAM_ARB_STARVE_GUARD_EN
    localparam bit GUARD = 1'b1;
`else
    localparam bit GUARD = 1'b0;
`endif

    typedef struct {
        logic [7:0] data;
        int         due;
    } exp_t;

    logic          clock  = 1'b0;
    logic          reset  = 1'b0;
    logic          vreq   = 1'b0;
    logic [AW-1:0] va     = '0;
    logic          creq   = 1'b0;
    logic          cwr    = 1'b0;
    logic [AW-1:0] ca     = '0;
    logic [7:0]    cdi    = '0;
    logic [7:0]    vdo;
    logic [7:0]    cdo;
    logic          vack;
    logic          cack;
    logic          wait_n;
    logic          verr;
    logic [AW-1:0] mem_a;
    logic          mem_we;
    logic [7:0]    mem_di;
    logic [7:0]    mem_do;

    logic [7:0]    ram [0:(1<<AW)-1];
    bit            ram_loaded = 1'b0;
    int            cyc        = 0;
    int            n_checks   = 0;
    int            n_fail     = 0;
    logic [7:0]    exp_cdo    = 8'h00;
    exp_t          vq[$];
    exp_t          cq[$];

    vram_arbiter #(.AW(AW), .STARVE(STARVE)) dut (
        .clock (clock),
        .reset (reset),
        .vreq  (vreq),
        .va    (va),
        .vdo   (vdo),
        .vack  (vack),
        .creq  (creq),
        .cwr   (cwr),
        .ca    (ca),
        .cdi   (cdi),
        .cdo   (cdo),
        .cack  (cack),
        .wait_n(wait_n),
        .verr  (verr),
        .mem_a (mem_a),
        .mem_we(mem_we),
        .mem_di(mem_di),
        .mem_do(mem_do)
    );

    always #5 clock = ~clock;

    // Initial RAM contents; 0x0123 holds 0xA5
    function automatic logic [7:0] pat(input logic [AW-1:0] a);
        if (a == 14'h0123) return 8'hA5;
        return a[7:0] ^ {2'b00, a[13:8]} ^ 8'h5A;
    endfunction

    // Bank RAM: one-clock registered read, write on edge with mem_we
    always @(posedge clock) begin
        cyc <= cyc + 1;
        if (!ram_loaded) begin
            for (int i = 0; i < (1 << AW); i++) ram[i] <= pat(AW'(i));
            ram_loaded <= 1'b1;
        end else if (mem_we) begin
            ram[mem_a] <= mem_di;
        end
        mem_do <= ram[mem_a];
    end

    // Output monitor: wait_n relation every cycle, acks popped against the scoreboard
    always @(negedge clock) begin
        exp_t e;
        n_checks++;
        if (wait_n !== ~(creq & ~cack)) begin
            n_fail++;
            $display("FAIL wait_n: got %b, expected %b (creq=%b cack=%b) cycle %0d", wait_n, ~(creq & ~cack), creq, cack, cyc);
        end
        if (vack === 1'b1) begin
            n_checks++;
            if (vq.size() == 0) begin
                n_fail++;
                $display("FAIL vack_unexpected: vack high with vdo=%h at cycle %0d, expected none", vdo, cyc);
            end else begin
                e = vq.pop_front();
                if (vdo !== e.data || cyc != e.due) begin
                    n_fail++;
                    $display("FAIL vack_data: got vdo=%h at cycle %0d, expected %h at cycle %0d", vdo, cyc, e.data, e.due);
                end
            end
        end
        if (cack === 1'b1) begin
            n_checks++;
            if (cq.size() == 0) begin
                n_fail++;
                $display("FAIL cack_unexpected: cack high with cdo=%h at cycle %0d, expected none", cdo, cyc);
            end else begin
                e = cq.pop_front();
                if (cdo !== e.data || cyc != e.due) begin
                    n_fail++;
                    $display("FAIL cack_data: got cdo=%h at cycle %0d, expected %h at cycle %0d", cdo, cyc, e.data, e.due);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic push_v(input logic [7:0] d, input int due);
        exp_t e;
        e.data = d;
        e.due  = due;
        vq.push_back(e);
    endtask

    task automatic push_c(input logic [7:0] d, input int due);
        exp_t e;
        e.data = d;
        e.due  = due;
        cq.push_back(e);
    endtask

    // Step until cack is seen (requester drops creq in the cack cycle)
    task automatic cpu_wait(input int limit, output bit got);
        got = 1'b0;
        for (int i = 0; i < limit; i++) begin
            step();
            if (cack === 1'b1) begin
                got = 1'b1;
                break;
            end
        end
        creq = 1'b0;
        cwr  = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        creq  = 1'b1;
        repeat (3) step();
        n_checks++;
        if (wait_n !== 1'b0) begin n_fail++; $display("FAIL reset_wait_n_follows: got %b, expected 0", wait_n); end
        creq = 1'b0;
        #1;
        n_checks++;
        if (vdo !== 8'h00 || cdo !== 8'h00) begin n_fail++; $display("FAIL reset_data: got vdo=%h cdo=%h, expected 00 00", vdo, cdo); end
        n_checks++;
        if (vack !== 1'b0 || cack !== 1'b0 || verr !== 1'b0) begin
            n_fail++; $display("FAIL reset_flags: got vack=%b cack=%b verr=%b, expected 0 0 0", vack, cack, verr);
        end
        n_checks++;
        if (mem_we !== 1'b0 || mem_a !== '0 || wait_n !== 1'b1) begin
            n_fail++; $display("FAIL reset_port: got mem_we=%b mem_a=%h wait_n=%b, expected 0 0000 1", mem_we, mem_a, wait_n);
        end
        step();
        reset = 1'b1;
        repeat (2) step();
    endtask

    task automatic test_video_read();
        int k;
        k    = cyc;
        vreq = 1'b1;
        va   = 14'h0123;
        push_v(8'hA5, k + 3);
        step();
        vreq = 1'b0;
        repeat (4) step();
        n_checks++;
        if (vq.size() != 0) begin n_fail++; $display("FAIL video_read_done: %0d reads outstanding, expected 0", vq.size()); end
        n_checks++;
        if (verr !== 1'b0) begin n_fail++; $display("FAIL video_read_verr: got %b, expected 0", verr); end
    endtask

    task automatic test_cpu_write_read();
        int k;
        bit got;
        k    = cyc;
        creq = 1'b1;
        cwr  = 1'b1;
        ca   = 14'h1FFF;
        cdi  = 8'h3C;
        push_c(exp_cdo, k + 2);
        cpu_wait(10, got);
        n_checks++;
        if (!got) begin n_fail++; $display("FAIL cpu_write_timeout: no cack within 10 cycles, expected one"); end
        step();
        n_checks++;
        if (ram[14'h1FFF] !== 8'h3C) begin n_fail++; $display("FAIL cpu_write_ram: got %h, expected 3c", ram[14'h1FFF]); end
        k       = cyc;
        creq    = 1'b1;
        cwr     = 1'b0;
        exp_cdo = 8'h3C;
        push_c(exp_cdo, k + 3);
        cpu_wait(10, got);
        n_checks++;
        if (!got) begin n_fail++; $display("FAIL cpu_read_timeout: no cack within 10 cycles, expected one"); end
        repeat (2) step();
    endtask

    task automatic test_contention();
        int k;
        bit got;
        k       = cyc;
        vreq    = 1'b1;
        va      = 14'h0200;
        creq    = 1'b1;
        cwr     = 1'b0;
        ca      = 14'h0300;
        exp_cdo = pat(14'h0300);
        push_v(pat(14'h0200), k + 3);
        push_c(exp_cdo, k + 4);
        step();
        vreq = 1'b0;
        cpu_wait(10, got);
        n_checks++;
        if (!got) begin n_fail++; $display("FAIL contention_timeout: no cack within 10 cycles, expected one"); end
        repeat (3) step();
        n_checks++;
        if (vq.size() != 0) begin n_fail++; $display("FAIL contention_video: %0d reads outstanding, expected 0", vq.size()); end
    endtask

    // 20-clock vreq burst with a CPU read pending from the first edge
    task automatic test_starve();
        int k;
        bit got;
        bit late;
        k       = cyc;
        creq    = 1'b1;
        cwr     = 1'b0;
        ca      = 14'h0310;
        exp_cdo = pat(14'h0310);
        push_c(exp_cdo, GUARD ? k + 7 : k + 23);
        got = 1'b0;
        for (int i = 0; i < 20; i++) begin
            vreq = 1'b1;
            va   = AW'(32'h0400 + i);
            late = GUARD && (i >= 4);
            push_v(pat(va), late ? k + 4 + i : k + 3 + i);
            step();
            if (cack === 1'b1) begin
                creq = 1'b0;
                got  = 1'b1;
            end
        end
        vreq = 1'b0;
        n_checks++;
        if (got !== GUARD) begin n_fail++; $display("FAIL starve_burst_cack: cack during burst %b, expected %b", got, GUARD); end
        if (!got) cpu_wait(10, got);
        n_checks++;
        if (!got) begin n_fail++; $display("FAIL starve_timeout: no cack after burst, expected one"); end
        repeat (6) step();
        n_checks++;
        if (verr !== 1'b0) begin n_fail++; $display("FAIL starve_verr: got %b, expected 0", verr); end
    endtask

`ifdef VRAM_ARB_STARVE_GUARD_EN
    // Second forced CPU grant lands while a displaced video read is pending:
    // the pending address (index 11) is lost, the later one (index 12) is served
    task automatic test_overrun();
        int k;
        k       = cyc;
        creq    = 1'b1;
        cwr     = 1'b0;
        ca      = 14'h0320;
        exp_cdo = pat(14'h0320);
        push_c(exp_cdo, k + 7);
        for (int i = 0; i < 16; i++) begin
            vreq = 1'b1;
            va   = AW'(32'h0800 + i);
            if (i != 11) push_v(pat(va), (i < 4) ? k + 3 + i : k + 4 + i);
            step();
            if (cack === 1'b1) creq = 1'b0;
            if (i == 7) begin
                creq    = 1'b1;
                ca      = 14'h0330;
                exp_cdo = pat(14'h0330);
                push_c(exp_cdo, k + 15);
            end
            if (i == 11) begin
                n_checks++;
                if (verr !== 1'b0) begin n_fail++; $display("FAIL overrun_before: verr=%b at cycle %0d, expected 0", verr, cyc); end
            end
            if (i == 13) begin
                n_checks++;
                if (verr !== 1'b1) begin n_fail++; $display("FAIL overrun_set: verr=%b at cycle %0d, expected 1", verr, cyc); end
            end
        end
        vreq = 1'b0;
        creq = 1'b0;
        repeat (6) step();
    endtask
`endif

    task automatic test_reset_during_write();
        int k;
        k    = cyc;
        n_checks++;
        if (verr !== GUARD) begin n_fail++; $display("FAIL verr_sticky: got %b, expected %b", verr, GUARD); end
        creq = 1'b1;
        cwr  = 1'b1;
        ca   = 14'h0555;
        cdi  = 8'hEE;
        step();
        #2;
        n_checks++;
        if (mem_we !== 1'b1) begin n_fail++; $display("FAIL rst_write_state: mem_we=%b at cycle %0d (start %0d), expected 1", mem_we, cyc, k); end
        reset = 1'b0;
        #1;
        n_checks++;
        if (mem_we !== 1'b0 || mem_a !== '0) begin n_fail++; $display("FAIL rst_port: got mem_we=%b mem_a=%h, expected 0 0000", mem_we, mem_a); end
        n_checks++;
        if (vdo !== 8'h00 || cdo !== 8'h00 || vack !== 1'b0 || cack !== 1'b0 || verr !== 1'b0) begin
            n_fail++; $display("FAIL rst_outputs: got vdo=%h cdo=%h vack=%b cack=%b verr=%b, expected 00 00 0 0 0", vdo, cdo, vack, cack, verr);
        end
        n_checks++;
        if (wait_n !== 1'b0) begin n_fail++; $display("FAIL rst_wait_n: got %b, expected 0", wait_n); end
        step();
        creq = 1'b0;
        cwr  = 1'b0;
        step();
        reset = 1'b1;
        repeat (3) step();
        exp_cdo = 8'h00;
        n_checks++;
        if (ram[14'h0555] !== pat(14'h0555)) begin n_fail++; $display("FAIL rst_ram_unchanged: got %h, expected %h", ram[14'h0555], pat(14'h0555)); end
    endtask

    initial begin
        test_reset();
        test_video_read();
        test_cpu_write_read();
        test_contention();
        test_starve();
`ifdef VRAM_ARB_STARVE_GUARD_EN
        test_overrun();
`endif
        test_reset_during_write();
        repeat (4) step();
        n_checks++;
        if (vq.size() != 0 || cq.size() != 0) begin
            n_fail++; $display("FAIL scoreboard_drain: %0d video and %0d cpu left, expected 0 0", vq.size(), cq.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
